// File: rtl/arb_mux_reg_if.sv
// Handshake bundle for arb_mux_reg: N_IN valid/ready producer channels in,
// one registered valid/ready channel out, plus the mode/select controls.
interface arb_mux_reg_if #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 3,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [N_IN-1:0]         in_valid;
    logic [N_IN*WIDTH-1:0]   in_data;
    logic [N_IN-1:0]         in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_ready;

    // Driver side: producers, control unit and consumer.
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // Selector side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/arb_mux_reg.sv
// N-input selector with a registered output: explicit select (mode 0) or
// round-robin arbitration (mode 1), valid/ready on every channel.
module arb_mux_reg #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 3
) (
    input  logic          clk,
    input  logic          reset,
    arb_mux_reg_if.slave  bus
);
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] idx;
    } grant_t;

    logic [SEL_W-1:0] ptr;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;

    logic [WIDTH-1:0] chan [N_IN];
    grant_t           gnt;
    logic [N_IN-1:0]  ready;
    logic             can_load;
    logic             xfer;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            chan[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        logic [SEL_W:0] sum;
        gnt = '0;
        sum = '0;
        if (mode_e'(bus.mode) == MODE_RR) begin
            // Cyclic search starting at ptr; the first requester wins.
            for (int k = 0; k < N_IN; k++) begin
                sum = {1'b0, ptr} + (SEL_W+1)'(k);
                if (sum >= (SEL_W+1)'(N_IN)) sum = sum - (SEL_W+1)'(N_IN);
                if (!gnt.hit && bus.in_valid[sum[SEL_W-1:0]]) begin
                    gnt.hit = 1'b1;
                    gnt.idx = sum[SEL_W-1:0];
                end
            end
        end else begin
            // Out-of-range select leaves idx at its default of channel 0.
            for (int i = 0; i < N_IN; i++) begin
                if (bus.sel == SEL_W'(i)) gnt.idx = SEL_W'(i);
            end
            gnt.hit = bus.in_valid[gnt.idx];
        end
    end

    assign can_load = !out_valid_q || bus.out_ready;

    // A handshake during reset would be discarded, so none is offered.
    always_comb begin
        ready = '0;
        if (!reset && can_load && gnt.hit) ready[gnt.idx] = 1'b1;
    end

    assign xfer = |ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr         <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= chan[gnt.idx];
            out_src_q   <= gnt.idx;
            if (mode_e'(bus.mode) == MODE_RR) begin
                ptr <= (gnt.idx == SEL_W'(N_IN-1)) ? '0 : gnt.idx + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg (N_IN=3, WIDTH=16): reset, mode 0 select,
// round-robin rotation and sparse requests, backpressure and mid-stall reset.
module tb_arb_mux_reg;
    localparam int WIDTH = 16;
    localparam int N_IN  = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    arb_mux_reg_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();

    arb_mux_reg #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already applied: checks in_ready,
    // crosses one rising edge, then checks the output register.
    task automatic beat(input string tag, input logic [2:0] exp_ready,
                        input logic exp_valid, input logic [1:0] exp_src,
                        input logic [15:0] exp_data);
        #1;
        check({tag, ".in_ready"}, bus.in_ready, exp_ready);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".out_valid"}, bus.out_valid, exp_valid);
        check({tag, ".out_src"},   bus.out_src,   exp_src);
        check({tag, ".out_data"},  bus.out_data,  exp_data);
    endtask

    logic [1:0]  rot_src [5]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [15:0] rot_data [5] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hAAAA, 16'hBBBB};
    logic [2:0]  rot_rdy [5]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [1:0]  sp_src [4]   = '{2'd2, 2'd0, 2'd2, 2'd0};
    logic [15:0] sp_data [4]  = '{16'hCCCC, 16'hAAAA, 16'hCCCC, 16'hAAAA};
    logic [2:0]  sp_rdy [4]   = '{3'b100, 3'b001, 3'b100, 3'b001};

    initial begin
        reset         = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_valid  = 3'b111;
        bus.in_data   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        bus.out_ready = 1'b1;

        // Reset held for two edges with all channels requesting.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst.out_valid", bus.out_valid, 1'b0);
            check("rst.out_data",  bus.out_data,  16'h0);
            check("rst.out_src",   bus.out_src,   2'd0);
            check("rst.in_ready",  bus.in_ready,  3'b000);
        end
        reset = 1'b0;

        // Round-robin rotation, first grant after reset is channel 0.
        for (int i = 0; i < 5; i++) beat($sformatf("rot%0d", i), rot_rdy[i], 1'b1, rot_src[i], rot_data[i]);

        // Sparse requests from ptr=2: grants alternate 2,0,2,0.
        bus.in_valid = 3'b101;
        for (int i = 0; i < 4; i++) beat($sformatf("sparse%0d", i), sp_rdy[i], 1'b1, sp_src[i], sp_data[i]);

        // Channel 1 joins after a grant to 0 and wins next.
        bus.in_valid = 3'b111;
        beat("join1", 3'b010, 1'b1, 2'd1, 16'hBBBB);

        // No requests: no ready, register drains.
        bus.in_valid = 3'b000;
        beat("idle_rr", 3'b000, 1'b0, 2'd1, 16'hBBBB);

        // Mode 0 explicit select, then out-of-range select.
        bus.in_valid = 3'b111;
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        beat("sel2", 3'b100, 1'b1, 2'd2, 16'hCCCC);
        bus.sel = 2'd3;
        beat("sel3", 3'b001, 1'b1, 2'd0, 16'hAAAA);

        // Selected channel idle: nothing transfers although others request.
        bus.sel      = 2'd1;
        bus.in_valid = 3'b101;
        beat("sel_idle", 3'b000, 1'b0, 2'd0, 16'hAAAA);

        // Mode 0 left ptr at 2.
        bus.mode     = 1'b1;
        bus.in_valid = 3'b111;
        beat("ptr_kept", 3'b100, 1'b1, 2'd2, 16'hCCCC);

        // Backpressure with a mode/sel change during the stall.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.mode = 1'b0;
                bus.sel  = 2'd1;
            end
            beat($sformatf("stall%0d", i), 3'b000, 1'b1, 2'd2, 16'hCCCC);
        end
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        beat("refill", 3'b001, 1'b1, 2'd0, 16'hAAAA);

        // Reset while stalled discards the held word and rewinds ptr.
        bus.out_ready = 1'b0;
        beat("pre_rst", 3'b000, 1'b1, 2'd0, 16'hAAAA);
        reset = 1'b1;
        beat("mid_rst", 3'b000, 1'b0, 2'd0, 16'h0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        beat("post_rst", 3'b001, 1'b1, 2'd0, 16'hAAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
